rr_shared_reg_arbiter: RTL and testbench

- Round-robin arbiter and write sequencer for one shared W-bit register. The register is the enable plus synchronous-reset D flip-flop type used in the flip-flop library.
- N requesters compete to load their data word into the register. The block grants one requester at a time, drives the register's enable and data, and exposes the stored value.
- The block sits between several producers and a single shared state register.

---
 rtl/rr_arb_pkg.sv | 18 +
 rtl/rr_shared_reg_arbiter_pick.sv | 39 +++
 rtl/rr_shared_reg_arbiter.sv | 110 +++++++++++
 tb/tb_rr_shared_reg_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin shared-register arbiter:
// FSM state encoding, index-width helper and default sizing.
package rr_arb_pkg;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned DEF_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_shared_reg_arbiter_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping past N-1 back to 0.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] winner
);

  logic          hi_any;
  logic [IW-1:0] hi_win;
  logic [IW-1:0] lo_win;

  // Descending scans leave the lowest matching index in each candidate:
  // hi_* covers indices >= ptr, lo_* is the wrap-around fallback.
  always_comb begin
    hi_any = 1'b0;
    hi_win = '0;
    lo_win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_win = IW'(i);
        if (IW'(i) >= ptr) begin
          hi_any = 1'b1;
          hi_win = IW'(i);
        end
      end
    end
  end

  assign any    = |req;
  assign winner = hi_any ? hi_win : lo_win;

endmodule

// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin write sequencer for one shared enable/sync-reset register:
// grants one requester per two cycles and loads its word in the GRANT cycle.
module rr_shared_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned W  = DEF_W,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  input  logic           clr,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           busy,
  output logic [IW-1:0]  last_id
);

  state_e        state_q;
  logic [N-1:0]  gnt_q;
  logic          busy_q;
  logic [IW-1:0] last_id_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] sel_q;
  logic [W-1:0]  q_q;

  logic          pick_any;
  logic [IW-1:0] pick_win;
  logic [N-1:0]  win_onehot;
  logic [IW-1:0] ptr_d;
  logic          reg_en;
  logic          reg_srst;
  logic [W-1:0]  reg_d;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_win)
  );

  always_comb begin
    win_onehot = '0;
    win_onehot[pick_win] = 1'b1;
  end

  // Pointer wraps at N so non-power-of-two requester counts stay in range.
  assign ptr_d = (sel_q == IW'(N - 1)) ? '0 : sel_q + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      last_id_q <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!clr && pick_any) begin
            gnt_q   <= win_onehot;
            sel_q   <= pick_win;
            busy_q  <= 1'b1;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          gnt_q     <= '0;
          busy_q    <= 1'b0;
          last_id_q <= sel_q;
          ptr_q     <= ptr_d;
          state_q   <= ST_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Shared register: loads during GRANT, cleared by reset or by clr in IDLE.
  assign reg_en   = (state_q == ST_GRANT);
  assign reg_srst = rst | (clr & (state_q == ST_IDLE));

  always_comb begin
    reg_d = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_q == IW'(i)) reg_d = wdata[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (reg_srst)    q_q <= '0;
    else if (reg_en) q_q <= reg_d;
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign busy    = busy_q;
  assign last_id = last_id_q;

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// Bench for rr_shared_reg_arbiter: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a behavioural model.
module tb_rr_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           clr;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           busy;
  logic [IW-1:0]  last_id;

  int total = 0;
  int bad   = 0;

  // Model: index of the requester holding the grant this cycle (-1 if none).
  int m_grant = -1;
  int m_ptr   = 0;
  int m_last  = 0;
  int m_q     = 0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  rr_shared_reg_arbiter #(.N(N), .W(W), .IW(IW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .clr     (clr),
    .gnt     (gnt),
    .q       (q),
    .busy    (busy),
    .last_id (last_id)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int word(input int i);
    return int'(wdata[i*W +: W]);
  endfunction

  task automatic set_word(input int i, input int v);
    wdata[i*W +: W] = W'(v);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_grant = -1;
      m_q     = 0;
      m_last  = 0;
      m_ptr   = 0;
      m_valid = 1'b1;
    end else if (m_grant >= 0) begin
      m_q     = word(m_grant);
      m_last  = m_grant;
      m_ptr   = (m_grant + 1) % N;
      m_grant = -1;
    end else if (clr) begin
      m_q = 0;
    end else if (req != '0) begin
      for (int k = 0; k < N; k++) begin
        if (req[(m_ptr + k) % N]) begin
          m_grant = (m_ptr + k) % N;
          break;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_gnt", int'(gnt), (m_grant >= 0) ? (1 << m_grant) : 0);
      check("model_busy", int'(busy), (m_grant >= 0) ? 1 : 0);
      check("model_q", int'(q), m_q);
      check("model_last_id", int'(last_id), m_last);
    end
  end

  initial begin
    rst   = 1'b1;
    clr   = 1'b0;
    req   = N'($urandom);
    wdata = $urandom;
    repeat (2) begin
      @(negedge clk);
      req   = N'($urandom);
      wdata = $urandom;
    end

    // Reset state after two reset edges
    @(negedge clk);
    check("rst_q", int'(q), 0);
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_last_id", int'(last_id), 0);

    // Fair rotation with all requesters held
    rst   = 1'b0;
    req   = 4'b1111;
    wdata = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rot_gnt", int'(gnt), 1 << (k % 4));
      check("rot_busy", int'(busy), 1);
      @(negedge clk);
      check("rot_q", int'(q), 'h10 + (k % 4));
      check("rot_gnt_off", int'(gnt), 0);
      check("rot_last_id", int'(last_id), k % 4);
      if (k == 4) req = '0;
    end

    // Single writer
    req = 4'b0001;
    set_word(0, 'hA5);
    @(negedge clk);
    check("single_gnt", int'(gnt), 1);
    check("single_busy", int'(busy), 1);
    req = '0;
    @(negedge clk);
    check("single_q", int'(q), 'hA5);
    check("single_last_id", int'(last_id), 0);
    check("single_busy_off", int'(busy), 0);

    // Pointer wrap: grant 2, then 0101 picks 0 then 2
    req = 4'b0100;
    set_word(2, 'h22);
    @(negedge clk);
    check("wrap_gnt2", int'(gnt), 4);
    req = '0;
    @(negedge clk);
    check("wrap_q2", int'(q), 'h22);
    req = 4'b0101;
    @(negedge clk);
    check("wrap_gnt0", int'(gnt), 1);
    req = 4'b0100;
    @(negedge clk);
    check("wrap_q0", int'(q), 'hA5);
    @(negedge clk);
    check("wrap_gnt2b", int'(gnt), 4);
    req = '0;
    @(negedge clk);
    check("wrap_q2b", int'(q), 'h22);

    // Clear beats a simultaneous request
    req = 4'b1000;
    set_word(3, 'h55);
    @(negedge clk);
    check("clr_setup_gnt", int'(gnt), 8);
    req = '0;
    @(negedge clk);
    check("clr_setup_q", int'(q), 'h55);
    clr = 1'b1;
    req = 4'b0010;
    set_word(1, 'h66);
    @(negedge clk);
    check("clr_q", int'(q), 0);
    check("clr_gnt", int'(gnt), 0);
    clr = 1'b0;
    @(negedge clk);
    check("clr_then_gnt", int'(gnt), 2);
    req = '0;
    @(negedge clk);
    check("clr_then_q", int'(q), 'h66);
    check("clr_then_last", int'(last_id), 1);

    // Reset during GRANT aborts the write and clears the pointer
    req = 4'b0100;
    set_word(2, 'h3C);
    @(negedge clk);
    check("rstg_gnt", int'(gnt), 4);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("rstg_gnt_off", int'(gnt), 0);
    check("rstg_q", int'(q), 0);
    rst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    check("rstg_first_gnt", int'(gnt), 1);
    req = '0;

    // Randomized traffic; the per-cycle compare process does the checking
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if (m_grant == i) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
        end
        if (m_grant != i) set_word(i, int'($urandom_range(0, 255)));
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
